// File: rtl/serial_pkg.sv
// Purpose : shared types and line constants for the serial shift register / deserializer pair.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: receiver FSM state enum, line-level constants, shift register mode codes.
package serial_pkg;

    // Receiver frame states. PARITY is only reachable when PARITY_CHECK_EN is defined.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        PARITY = 3'd2,
        STOP   = 3'd3,
        BREAK  = 3'd4
    } state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Operating modes of the transmit-side shift register; kept here so both ends agree.
    typedef enum logic [1:0] {
        MODE_SHIFT  = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_LOAD   = 2'd2
    } mode_e;

endpackage

// File: rtl/serial_deserializer_if.sv
// Purpose : bundles the serial line, bit strobe and the parallel word handshake of the deserializer.
// Latency : n/a (wiring only).
// Backpr. : READY from the consumer; VALID held until accepted.
// Modports: master = the deserializer (drives Q/VALID/flags), slave = line driver + consumer.
interface serial_deserializer_if #(
    parameter int WIDTH = 4
);
    logic             ENB;
    logic             S_IN;
    logic             DIR;
    logic             READY;
    logic [WIDTH-1:0] Q;
    logic             VALID;
    logic             BUSY;
    logic             FRAME_ERR;
    logic             OVERRUN;
    logic             PAR_ERR;

    modport master (
        input  ENB, S_IN, DIR, READY,
        output Q, VALID, BUSY, FRAME_ERR, OVERRUN, PAR_ERR
    );

    modport slave (
        output ENB, S_IN, DIR, READY,
        input  Q, VALID, BUSY, FRAME_ERR, OVERRUN, PAR_ERR
    );
endinterface

// File: rtl/deser_shift_reg.sv
// Purpose : WIDTH-bit collect register with direction-selected insertion and a bit counter.
// Latency : one shift per shift_en edge; done is combinational on the WIDTH-th shift.
// Backpr. : none; shifts only when shift_en=1, otherwise holds.
// Ports   : clk, rst (sync, high), clear (restart count), shift_en, dir (0 = MSB-first), s_in -> collect, done.
module deser_shift_reg
    import serial_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             dir,
    input  logic             s_in,
    output logic [WIDTH-1:0] collect,
    output logic             done
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt;

    assign done = shift_en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            collect <= '0;
            cnt     <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (shift_en) begin
            // dir=0: first bit migrates up to the MSB; dir=1: first bit migrates down to the LSB.
            if (dir) begin
                collect <= {s_in, collect[WIDTH-1:1]};
            end else begin
                collect <= {collect[WIDTH-2:0], s_in};
            end
            cnt <= done ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/serial_deserializer.sv
// Purpose : framed serial-to-parallel receiver (start, WIDTH data, [even parity], stop) with frame/overrun flags.
// Latency : word valid on the edge that samples a good stop bit (WIDTH+2 enabled edges, +1 with parity).
// Backpr. : VALID/READY; a word arriving while VALID=1 and READY=0 is dropped and OVERRUN latches.
// Ports   : clk, RST (sync, active-high), bus (serial_deserializer_if.master: ENB, S_IN, DIR, READY, Q, VALID,
//           BUSY, FRAME_ERR, OVERRUN, PAR_ERR). Macro PARITY_CHECK_EN adds the parity bit and PAR_ERR.
module serial_deserializer
    import serial_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  RST,
    serial_deserializer_if.master bus
);
    state_e           state_q;
    state_e           state_d;
    logic             dir_q;
    logic             latch_dir;
    logic             sr_clear;
    logic             sr_shift;
    logic             sr_done;
    logic [WIDTH-1:0] collect;
    logic             deliver;
    logic             bad_stop;
    logic [WIDTH-1:0] q_r;
    logic             valid_r;
    logic             frame_err_r;
    logic             overrun_r;
`ifdef PARITY_CHECK_EN
    logic             par_sample;
    logic             par_bit_q;
    logic             par_err_r;
`endif

    deser_shift_reg #(.WIDTH(WIDTH)) u_shift (
        .clk      (clk),
        .rst      (RST),
        .clear    (sr_clear),
        .shift_en (sr_shift),
        .dir      (dir_q),
        .s_in     (bus.S_IN),
        .collect  (collect),
        .done     (sr_done)
    );

    always_comb begin
        state_d   = state_q;
        latch_dir = 1'b0;
        sr_clear  = 1'b0;
        sr_shift  = 1'b0;
        deliver   = 1'b0;
        bad_stop  = 1'b0;
`ifdef PARITY_CHECK_EN
        par_sample = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.ENB && bus.S_IN == START_BIT) begin
                    state_d   = DATA;
                    latch_dir = 1'b1;
                    sr_clear  = 1'b1;
                end
            end
            DATA: begin
                if (bus.ENB) begin
                    sr_shift = 1'b1;
                    if (sr_done) begin
`ifdef PARITY_CHECK_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
            PARITY: begin
`ifdef PARITY_CHECK_EN
                if (bus.ENB) begin
                    par_sample = 1'b1;
                    state_d    = STOP;
                end
`else
                state_d = IDLE;
`endif
            end
            STOP: begin
                if (bus.ENB) begin
                    if (bus.S_IN == STOP_BIT) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bad_stop = 1'b1;
                        state_d  = BREAK;
                    end
                end
            end
            BREAK: begin
                // A held-low line must return to idle before a new start bit is honoured.
                if (bus.ENB && bus.S_IN == LINE_IDLE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q     <= IDLE;
            dir_q       <= 1'b0;
            q_r         <= '0;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_bit_q   <= 1'b0;
            par_err_r   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            frame_err_r <= bad_stop;
            if (latch_dir) begin
                dir_q <= bus.DIR;
            end
`ifdef PARITY_CHECK_EN
            if (par_sample) begin
                par_bit_q <= bus.S_IN;
            end
`endif
            // A delivery that coincides with acceptance simply replaces the word; VALID stays up.
            if (deliver && (!valid_r || bus.READY)) begin
                q_r     <= collect;
                valid_r <= 1'b1;
`ifdef PARITY_CHECK_EN
                par_err_r <= (^collect) ^ par_bit_q;
`endif
            end else begin
                if (deliver) begin
                    overrun_r <= 1'b1;
                end
                if (valid_r && bus.READY) begin
                    valid_r <= 1'b0;
`ifdef PARITY_CHECK_EN
                    par_err_r <= 1'b0;
`endif
                end
            end
        end
    end

    assign bus.Q         = q_r;
    assign bus.VALID     = valid_r;
    assign bus.BUSY      = (state_q != IDLE);
    assign bus.FRAME_ERR = frame_err_r;
    assign bus.OVERRUN   = overrun_r;
`ifdef PARITY_CHECK_EN
    assign bus.PAR_ERR   = par_err_r;
`else
    assign bus.PAR_ERR   = 1'b0;
`endif
endmodule
